// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and upper-digit stage: runs the start/stop/lap/reset FSM,
// counts seconds and minutes from the centisecond carry, and drives a lap-freezable display.
module stopwatch_ctrl #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_clk,
  input  logic [6:0] cs_value,
  input  logic       start_stop,
  input  logic       lap_reset,
  output logic       cs_run,
  output logic       cs_clr_n,
  output logic [6:0] disp_cs,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] LAP   = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;

  localparam logic [5:0] SEC_LAST = 6'(SEC_MAX);
  localparam logic [5:0] MIN_LAST = 6'(MIN_MAX);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       clear_cnt;
  logic       cs_prev;
  logic       tick;
  logic       counting;
  logic [5:0] sec;
  logic [5:0] min;

  assign tick     = cs_clk & ~cs_prev;
  assign counting = (state == RUN) || (state == LAP);

  // Outputs decode the state register only, so they change one cycle after a pulse.
  assign running    = counting;
  assign cs_run     = counting;
  assign lap_active = (state == LAP);
  assign cs_clr_n   = (state != IDLE);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx  = state;
    clear_cnt = 1'b0;
    if (start_stop) begin
      // start_stop has priority; a simultaneous lap_reset is dropped.
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     state_nx = PAUSE;
        LAP:     state_nx = PAUSE;
        PAUSE:   state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end else if (lap_reset) begin
      case (state)
        IDLE:    state_nx = IDLE;
        RUN:     state_nx = LAP;
        LAP:     state_nx = RUN;
        PAUSE: begin
          state_nx  = IDLE;
          clear_cnt = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cs_prev  <= 1'b0;
      sec      <= '0;
      min      <= '0;
      overflow <= 1'b0;
      disp_cs  <= '0;
      disp_sec <= '0;
      disp_min <= '0;
    end else begin
      state   <= state_nx;
      cs_prev <= cs_clk;

      // Display tracks live values except while a lap is frozen.
      if (state != LAP) begin
        disp_cs  <= cs_value;
        disp_sec <= sec;
        disp_min <= min;
      end

      if (clear_cnt) begin
        sec      <= '0;
        min      <= '0;
        overflow <= 1'b0;
      end else if (tick && counting) begin
        if (sec < SEC_LAST) begin
          sec <= sec + 6'd1;
        end else if (min < MIN_LAST) begin
          sec <= '0;
          min <= min + 6'd1;
        end else begin
          sec      <= '0;
          min      <= '0;
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
